regfile_writeback: RTL
======================

# regfile_writeback

Writeback stage sitting directly upstream of the 32x32 register set's write port (`write`, `w_addr`, `w_data`). It merges two result sources into the single write port: single-cycle ALU results and variable-latency load returns from the load/store unit. Load returns are buffered in a small FIFO, sign- or zero-extended and lane-aligned. A starvation counter guarantees loads retire under continuous ALU traffic. Writes to x0 are suppressed here, because the register set itself does not protect x0.

## Interface
- `LQ_DEPTH`, 2: load-return FIFO depth (power of two, ≥2)
- `STARVE_MAX`, 4: consecutive cycles a load may wait behind ALU results before the ALU source is stalled (≥1)

- `clk`  in  1  clock; all state updates on rising edge
- `rstn`  in  1  asynchronous active-low reset
- `alu_valid`  in  1  ALU result present this cycle
- `alu_rd`  in  5  ALU destination register
- `alu_data`  in  32  ALU result
- `alu_stall`  out  1  upstream must hold its ALU result (`alu_valid`/`alu_rd`/`alu_data`) stable
- `ld_valid`  in  1  load return offered
- `ld_ready`  out  1  load FIFO can accept; transfer on `ld_valid & ld_ready`
- `ld_rd`  in  5  load destination register
- `ld_data`  in  32  raw aligned memory word
- `ld_size`  in  2  00 byte, 01 half, 10/11 word
- `ld_unsigned`  in  1  1 = zero-extend, 0 = sign-extend
- `ld_byte_off`  in  2  byte offset within word
- `write`  out  1  register-set write enable (registered)
- `w_addr`  out  5  register-set write address (registered)
- `w_data`  out  32  register-set write data (registered)

## Operation
- **Load FIFO.** FIFO of `LQ_DEPTH` entries holds {rd, extended data}.
  - Extension is applied on push.
  - Byte: lane `ld_data[8*off+:8]`.
  - Half: lane `ld_data[16*off[1]+:16]`; `off[0]` is ignored.
  - Word: `off` is ignored.
  - Fill bits are 0 when `ld_unsigned=1`; otherwise they copy the lane MSB.
- **`ld_ready`.** Equals `!full`, decided from the registered count only. A push is never accepted on a full cycle, even if a pop occurs in the same cycle.
- **Per-cycle selection.** Exactly one source wins the write port each cycle:
  - If `alu_valid & !alu_stall`: the ALU wins. If the FIFO is non-empty, the starvation counter increments.
  - Else if the FIFO is non-empty: the head pops and wins. The starvation counter clears.
  - Else: no write. The starvation counter clears.
- **Starvation.** When the counter reaches `STARVE_MAX`, `alu_stall` is registered high for exactly one cycle.
  - During that cycle `alu_valid` is ignored and the FIFO head pops.
  - The counter clears; `alu_stall` falls the next cycle.
- **x0 suppression.** A winner with rd=0 registers `write=0`.
  - A load still pops.
  - `w_addr` and `w_data` still update, but their values are don't-care.
- **Simultaneous push and pop** on a non-full FIFO: count is unchanged and the ordering is preserved. A push into an empty FIFO cannot pop in the same cycle.
- **Pointer wrap-around** is modulo `LQ_DEPTH`. Count width is clog2(`LQ_DEPTH`)+1.
- **Reset** (asynchronous, at any point including mid-stall):
  - `write=0`, `w_addr=0`, `w_data=0`, `alu_stall=0`.
  - FIFO emptied, so `ld_ready=1` after reset.
  - Starvation counter cleared.
  - Buffered loads are discarded.

## Timing
- **ALU result:** accepted at edge N, appears on `write`/`w_addr`/`w_data` after edge N, and is committed to the register set at edge N+1.
- **Load return:** minimum latency is push at edge N, pop at edge N+1, outputs valid after N+1.
- **`alu_stall`:** registered. It is asserted the cycle after the counter reaches `STARVE_MAX` and lasts exactly one cycle.
- **Data registers:** no combinational path from any input to `write`, `w_addr` or `w_data`.
- **`ld_ready`:** depends only on state.
- **Throughput:** one register write per cycle maximum. A sustained load rate above 1/(`STARVE_MAX`+1) under full ALU traffic back-pressures via `ld_ready`.

## Test plan
- **Reset:** assert `rstn=0` mid-traffic with 2 loads buffered → outputs zero immediately, `ld_ready=1`, `alu_stall=0`; the buffered loads never appear after release.
- **ALU only:** `alu_valid=1`, rd=5, data=0xDEADBEEF → next cycle `write=1`, `w_addr=5`, `w_data=0xDEADBEEF`. With rd=0 → `write=0`.
- **Load extension** (word 0x8081_F2F3):
  - byte off=1, signed → 0xFFFF_FFF2
  - byte off=1, unsigned → 0x0000_00F2
  - half off=2, signed → 0xFFFF_8081
  - word → 0x8081_F2F3
- **Priority and starvation:** continuous `alu_valid` with 1 load pushed, `STARVE_MAX=4` → 4 ALU writes, `alu_stall=1` for one cycle, load written in that cycle, ALU resumes with its held result unlost.
- **FIFO full:** push 2 loads while the ALU is busy → `ld_ready=0` on the third offer; that offer is held and accepted only after a pop. Order is preserved across pointer wrap (3+ loads).
- **Load to x0:** load with rd=0 followed by load rd=7 → first produces `write=0` but frees its slot; second writes x7 on the following cycle.

Source files
------------

// File: rtl/regfile_writeback.sv
// regfile_writeback
//   Writeback stage in front of the 32x32 register set write port. Merges
//   single-cycle ALU results with buffered load returns, extends and
//   lane-aligns loads on entry to a small FIFO, guarantees load forward
//   progress with a starvation counter, and suppresses writes to x0.
//
// Ports
//   clk, rstn                      clock, asynchronous active-low reset
//   alu_valid, alu_rd, alu_data    ALU result (held by upstream while alu_stall)
//   alu_stall                      one-cycle stall forcing a load to retire
//   ld_valid, ld_ready             load return handshake
//   ld_rd, ld_data, ld_size,
//   ld_unsigned, ld_byte_off       load return payload
//   write, w_addr, w_data          registered register-set write port
module regfile_writeback #(
  parameter int unsigned LQ_DEPTH   = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_stall,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  input  logic [1:0]  ld_byte_off,
  output logic        write,
  output logic [4:0]  w_addr,
  output logic [31:0] w_data
);

  localparam int unsigned PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(LQ_DEPTH) + 1;
  localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } lq_entry_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  lq_entry_t        lq_mem [LQ_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] lq_count;
  logic             lq_empty;
  logic             lq_full;
  logic             push;
  logic             pop;
  logic             alu_win;
  lq_entry_t        push_entry;
  lq_entry_t        head;

  logic [7:0]       lane_b;
  logic [15:0]      lane_h;
  logic             fill;

  state_t           state;
  state_t           state_next;
  logic [STV_W-1:0] starve_cnt;
  logic [STV_W-1:0] starve_next;

  // FIFO status comes from registered count only, so ld_ready has no input path
  assign lq_empty  = (lq_count == '0);
  assign lq_full   = (lq_count == CNT_W'(LQ_DEPTH));
  assign ld_ready  = ~lq_full;
  assign push      = ld_valid & ~lq_full;
  assign alu_stall = (state == ST_STALL);
  assign alu_win   = alu_valid & ~alu_stall;
  assign pop       = ~alu_win & ~lq_empty;
  assign head      = lq_mem[rd_ptr];

  // Lane selection and sign/zero extension of the incoming load word
  always_comb begin
    lane_b          = ld_data[7:0];
    lane_h          = ld_data[15:0];
    fill            = 1'b0;
    push_entry.rd   = ld_rd;
    push_entry.data = ld_data;
    case (ld_byte_off)
      2'd1:    lane_b = ld_data[15:8];
      2'd2:    lane_b = ld_data[23:16];
      2'd3:    lane_b = ld_data[31:24];
      default: lane_b = ld_data[7:0];
    endcase
    if (ld_byte_off[1]) begin
      lane_h = ld_data[31:16];
    end
    case (ld_size)
      2'b00: begin
        fill            = ~ld_unsigned & lane_b[7];
        push_entry.data = {{24{fill}}, lane_b};
      end
      2'b01: begin
        fill            = ~ld_unsigned & lane_h[15];
        push_entry.data = {{16{fill}}, lane_h};
      end
      default: push_entry.data = ld_data;
    endcase
  end

  // FIFO storage (data path, no reset needed)
  always_ff @(posedge clk) begin
    if (push) begin
      lq_mem[wr_ptr] <= push_entry;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      lq_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   lq_count <= lq_count + CNT_W'(1);
        2'b01:   lq_count <= lq_count - CNT_W'(1);
        default: lq_count <= lq_count;
      endcase
    end
  end

  // Starvation FSM: state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_RUN;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
    end
  end

  // Starvation FSM: count ALU wins over a waiting load; the count reaching
  // STARVE_MAX enters the one-cycle stall directly so the stall lands in
  // the cycle right after the final ALU win.
  always_comb begin
    state_next  = state;
    starve_next = '0;
    case (state)
      ST_RUN: begin
        if (alu_win && !lq_empty) begin
          if (starve_cnt == STV_W'(STARVE_MAX - 1)) begin
            state_next = ST_STALL;
          end else begin
            starve_next = starve_cnt + STV_W'(1);
          end
        end
      end
      ST_STALL: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // Registered write port; x0 targets still pop/update but never assert write
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      write  <= 1'b0;
      w_addr <= '0;
      w_data <= '0;
    end else if (alu_win) begin
      write  <= (alu_rd != 5'd0);
      w_addr <= alu_rd;
      w_data <= alu_data;
    end else if (pop) begin
      write  <= (head.rd != 5'd0);
      w_addr <= head.rd;
      w_data <= head.data;
    end else begin
      write  <= 1'b0;
    end
  end

endmodule
